signed_complement_unit: RTL and testbench

Parametrised digit-serial sign-conversion unit for the signed multiply/calculator datapath. It accepts a two's-complement operand and returns one of four results: pass, ones' complement, two's-complement negation or absolute value. A registered carry chain processes DIGIT bits per clock, with a start/busy/done handshake and most-negative overflow detection. The multiplier control uses it to build sign-magnitude operands ahead of the unsigned core and to re-sign the product afterwards.

---
 rtl/signed_complement_unit_if.sv | 24 ++
 rtl/signed_complement_unit.sv | 118 +++++++++++
 tb/tb_signed_complement_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/signed_complement_unit_if.sv
// Request/response bundle for signed_complement_unit: start/mode/operand in,
// busy/done handshake and converted result out.
interface signed_complement_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_start;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_a;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_sign_out;
  logic             o_ovf;

  modport master (
    output i_start, i_mode, i_a,
    input  o_busy, o_done, o_result, o_sign_out, o_ovf
  );

  modport slave (
    input  i_start, i_mode, i_a,
    output o_busy, o_done, o_result, o_sign_out, o_ovf
  );
endinterface

// File: rtl/signed_complement_unit.sv
// Digit-serial sign conversion (PASS / ONES / NEG / ABS), DIGIT bits per clock.
// Optional macro SIGN_CONV_SAT_EN saturates overflowing NEG/ABS to most-positive.
module signed_complement_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  signed_complement_unit_if.slave bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] M_ONES = 2'b01;
  localparam logic [1:0] M_NEG  = 2'b10;
  localparam logic [1:0] M_ABS  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_inv;
  logic             r_carry;
  logic             r_msb;
  logic             r_negabs;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_sign;
  logic             r_ovf;

  logic             w_neg_req;
  logic             w_inv_req;
  logic [DIGIT-1:0] w_digit;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_raw;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  // Invert/increment decision is made once, from the operand as presented with start
  assign w_neg_req = (bus.i_mode == M_NEG) | ((bus.i_mode == M_ABS) & bus.i_a[WIDTH-1]);
  assign w_inv_req = w_neg_req | (bus.i_mode == M_ONES);

  assign w_digit = r_op[DIGIT-1:0];
  assign w_sum   = {1'b0, w_digit ^ {DIGIT{r_inv}}} + {{DIGIT{1'b0}}, r_carry};
  assign w_raw   = (r_sh >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last  = (r_cnt == CW'(N - 1));
  assign w_ovf   = r_negabs & r_msb & w_raw[WIDTH-1];

`ifdef SIGN_CONV_SAT_EN
  assign w_res = w_ovf ? {1'b0, {(WIDTH-1){1'b1}}} : w_raw;
`else
  assign w_res = w_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_inv    <= 1'b0;
      r_carry  <= 1'b0;
      r_msb    <= 1'b0;
      r_negabs <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_sign   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_op     <= bus.i_a;
            r_msb    <= bus.i_a[WIDTH-1];
            r_negabs <= bus.i_mode[1];
            r_inv    <= w_inv_req;
            r_carry  <= w_neg_req;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          // LSB digit first; the carry out of the final digit is dropped
          r_op    <= r_op >> DIGIT;
          r_sh    <= w_raw;
          r_carry <= w_sum[DIGIT];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_res;
            r_sign   <= r_msb;
            r_ovf    <= w_ovf;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_result   = r_result;
  assign bus.o_sign_out = r_sign;
  assign bus.o_ovf      = r_ovf;

endmodule

// File: tb/tb_signed_complement_unit.sv
// Directed bench for signed_complement_unit: table of 8-bit/DIGIT=2 vectors plus
// hand sequences for busy-ignore, back-to-back, mid-run reset and other geometries.
module tb_signed_complement_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signed_complement_unit_if #(.WIDTH(8))  if0 ();
  signed_complement_unit_if #(.WIDTH(16)) if1 ();
  signed_complement_unit_if #(.WIDTH(8))  if2 ();

  signed_complement_unit #(.WIDTH(8),  .DIGIT(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  signed_complement_unit #(.WIDTH(16), .DIGIT(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  signed_complement_unit #(.WIDTH(8),  .DIGIT(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  localparam logic [1:0] PASS = 2'b00, ONES = 2'b01, NEG = 2'b10, ABS = 2'b11;

`ifdef SIGN_CONV_SAT_EN
  localparam logic [7:0]  MN8_RES  = 8'h7F;
  localparam logic [15:0] MN16_RES = 16'h7FFF;
`else
  localparam logic [7:0]  MN8_RES  = 8'h80;
  localparam logic [15:0] MN16_RES = 16'h8000;
`endif

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] res;
    logic       sign;
    logic       ovf;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int sel);
    case (sel) 0: return if0.o_busy; 1: return if1.o_busy; default: return if2.o_busy; endcase
  endfunction
  function automatic logic get_done(input int sel);
    case (sel) 0: return if0.o_done; 1: return if1.o_done; default: return if2.o_done; endcase
  endfunction
  function automatic logic [15:0] get_res(input int sel);
    case (sel) 0: return 16'(if0.o_result); 1: return if1.o_result; default: return 16'(if2.o_result); endcase
  endfunction
  function automatic logic get_sign(input int sel);
    case (sel) 0: return if0.o_sign_out; 1: return if1.o_sign_out; default: return if2.o_sign_out; endcase
  endfunction
  function automatic logic get_ovf(input int sel);
    case (sel) 0: return if0.o_ovf; 1: return if1.o_ovf; default: return if2.o_ovf; endcase
  endfunction

  task automatic drive(input int sel, input logic st, input logic [1:0] m, input logic [15:0] av);
    case (sel)
      0: begin if0.i_start = st; if0.i_mode = m; if0.i_a = av[7:0]; end
      1: begin if1.i_start = st; if1.i_mode = m; if1.i_a = av;      end
      default: begin if2.i_start = st; if2.i_mode = m; if2.i_a = av[7:0]; end
    endcase
  endtask

  // Present start for one edge; returns #1 after the accepting edge
  task automatic start_op(input int sel, input logic [1:0] m, input logic [15:0] av);
    @(negedge clk);
    drive(sel, 1'b1, m, av);
    @(posedge clk); #1;
    drive(sel, 1'b0, m, av);
  endtask

  // Counts edges until done is seen (bounded), tallying busy cycles
  task automatic wait_done(input int sel, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    forever begin
      if (get_busy(sel) && get_done(sel)) check("busy_and_done", 16'd1, 16'd0);
      if (get_done(sel)) break;
      if (get_busy(sel)) bc++;
      if (lat >= 40) begin
        check("done_timeout", 16'(lat), 16'd0);
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t vt[10];

  initial begin
    int lat, bc;
    vt[0] = '{NEG,  8'h05, 8'hFB,   1'b0, 1'b0};
    vt[1] = '{ONES, 8'hA5, 8'h5A,   1'b1, 1'b0};
    vt[2] = '{PASS, 8'h3C, 8'h3C,   1'b0, 1'b0};
    vt[3] = '{ABS,  8'hF6, 8'h0A,   1'b1, 1'b0};
    vt[4] = '{ABS,  8'h80, MN8_RES, 1'b1, 1'b1};
    vt[5] = '{NEG,  8'h00, 8'h00,   1'b0, 1'b0};
    vt[6] = '{NEG,  8'h80, MN8_RES, 1'b1, 1'b1};
    vt[7] = '{PASS, 8'h80, 8'h80,   1'b1, 1'b0};
    vt[8] = '{ONES, 8'h00, 8'hFF,   1'b0, 1'b0};
    vt[9] = '{ABS,  8'h7F, 8'h7F,   1'b0, 1'b0};

    for (int s = 0; s < 3; s++) drive(s, 1'b0, PASS, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   16'(get_busy(0)), 16'd0);
    check("rst_done",   16'(get_done(0)), 16'd0);
    check("rst_result", get_res(0),       16'h0);
    check("rst_ovf",    16'(get_ovf(0)),  16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      start_op(0, vt[i].mode, 16'(vt[i].a));
      wait_done(0, lat, bc);
      check($sformatf("v%0d_latency", i), 16'(lat), 16'd4);
      check($sformatf("v%0d_busy_cycles", i), 16'(bc), 16'd4);
      check($sformatf("v%0d_result", i), get_res(0), 16'(vt[i].res));
      check($sformatf("v%0d_sign", i), 16'(get_sign(0)), 16'(vt[i].sign));
      check($sformatf("v%0d_ovf", i), 16'(get_ovf(0)), 16'(vt[i].ovf));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 16'(get_done(0)), 16'd0);
    end

    // start during busy is ignored
    start_op(0, NEG, 16'h01);
    @(posedge clk); #1;
    drive(0, 1'b1, ABS, 16'h90);
    @(posedge clk); #1;
    drive(0, 1'b0, PASS, 16'h00);
    wait_done(0, lat, bc);
    check("ign_latency", 16'(lat), 16'd2);
    check("ign_result", get_res(0), 16'h00FF);
    check("ign_sign", 16'(get_sign(0)), 16'd0);

    // start held during the done cycle is accepted at once
    drive(0, 1'b1, ABS, 16'h90);
    @(posedge clk); #1;
    drive(0, 1'b0, PASS, 16'h00);
    check("b2b_busy", 16'(get_busy(0)), 16'd1);
    check("b2b_done", 16'(get_done(0)), 16'd0);
    check("b2b_hold_result", get_res(0), 16'h00FF);
    wait_done(0, lat, bc);
    check("b2b_latency", 16'(lat), 16'd4);
    check("b2b_result", get_res(0), 16'h0070);
    check("b2b_sign", 16'(get_sign(0)), 16'd1);
    check("b2b_ovf", 16'(get_ovf(0)), 16'd0);

    // reset in the 2nd RUN cycle aborts without a done pulse
    start_op(0, ABS, 16'h80);
    @(posedge clk); #1;
    check("abort_pre_busy", 16'(get_busy(0)), 16'd1);
    rst = 1'b1;
    #1;
    check("abort_busy",   16'(get_busy(0)), 16'd0);
    check("abort_done",   16'(get_done(0)), 16'd0);
    check("abort_result", get_res(0),       16'h0);
    check("abort_sign",   16'(get_sign(0)), 16'd0);
    check("abort_ovf",    16'(get_ovf(0)),  16'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (get_done(0) || get_busy(0)) seen++;
      end
      check("abort_no_done", 16'(seen), 16'd0);
    end
    start_op(0, NEG, 16'h7F);
    wait_done(0, lat, bc);
    check("post_rst_latency", 16'(lat), 16'd4);
    check("post_rst_result", get_res(0), 16'h0081);
    check("post_rst_sign", 16'(get_sign(0)), 16'd0);

    // WIDTH=16, DIGIT=4
    start_op(1, NEG, 16'h1234);
    wait_done(1, lat, bc);
    check("w16_latency", 16'(lat), 16'd4);
    check("w16_busy_cycles", 16'(bc), 16'd4);
    check("w16_neg_result", get_res(1), 16'hEDCC);
    check("w16_neg_ovf", 16'(get_ovf(1)), 16'd0);
    start_op(1, ABS, 16'h8000);
    wait_done(1, lat, bc);
    check("w16_abs_ovf", 16'(get_ovf(1)), 16'd1);
    check("w16_abs_result", get_res(1), MN16_RES);
    check("w16_abs_sign", 16'(get_sign(1)), 16'd1);

    // WIDTH=8, DIGIT=1
    start_op(2, NEG, 16'h05);
    wait_done(2, lat, bc);
    check("d1_latency", 16'(lat), 16'd8);
    check("d1_busy_cycles", 16'(bc), 16'd8);
    check("d1_result", get_res(2), 16'h00FB);
    start_op(2, ABS, 16'hF6);
    wait_done(2, lat, bc);
    check("d1_abs_result", get_res(2), 16'h000A);
    check("d1_abs_sign", 16'(get_sign(2)), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
